// File: rtl/mem_resp_queue_if.sv
// Request/response bundle between the MEM-stage tracker and its issuer/consumer.
// master = SRAM handshake + WB side driving inputs; slave = the queue itself.
interface mem_resp_queue_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              issue_valid;
  logic              issue_is_load;
  logic [1:0]        issue_size;
  logic              issue_signed;
  logic [OFF_W-1:0]  issue_offset;
  logic [TAG_W-1:0]  issue_tag;
  logic              issue_ready;
  logic              data_ok;
  logic [DATA_W-1:0] rdata;
  logic              flush;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic [TAG_W-1:0]  resp_tag;
  logic              resp_is_load;
  logic [CNT_W-1:0]  inflight;
  logic              cancel_busy;

  modport master (
    output issue_valid, issue_is_load, issue_size, issue_signed, issue_offset, issue_tag,
    output data_ok, rdata, flush, resp_ready,
    input  issue_ready, resp_valid, resp_data, resp_tag, resp_is_load, inflight, cancel_busy
  );

  modport slave (
    input  issue_valid, issue_is_load, issue_size, issue_signed, issue_offset, issue_tag,
    input  data_ok, rdata, flush, resp_ready,
    output issue_ready, resp_valid, resp_data, resp_tag, resp_is_load, inflight, cancel_busy
  );
endinterface

// File: rtl/mem_resp_queue.sv
// In-order MEM load/store response tracker; response visible same cycle as data_ok (bypass) or later from storage.
// Backpressure: issue_ready = !full from registered count only; head holds while resp_ready is low.
module mem_resp_queue #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int TAG_W  = 8
) (
  input logic          clk,
  input logic          reset,
  mem_resp_queue_if.slave q
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic             is_load;
    logic [1:0]       size;
    logic             sgn;
    logic [OFF_W-1:0] offset;
    logic [TAG_W-1:0] tag;
  } meta_t;

  logic [PTR_W-1:0]  head, tail, rp;
  logic [CNT_W-1:0]  count;
  logic [DEPTH-1:0]  e_done, e_cancel, occ;
  meta_t             e_meta [DEPTH];
  logic [DATA_W-1:0] e_data [DEPTH];

  logic              full, issue_fire, dok, head_occ, head_done, drop, pop, resp_valid_int;
  logic [DATA_W-1:0] head_data;
  meta_t             head_meta;

  function automatic logic [DATA_W-1:0] fmt_load(input logic [DATA_W-1:0] d, input meta_t m);
    logic [DATA_W-1:0] sh;
    sh = d >> {m.offset, 3'b000};
    case (m.size)
      2'd0:    fmt_load = m.sgn ? DATA_W'(signed'(sh[7:0]))  : DATA_W'(sh[7:0]);
      2'd1:    fmt_load = m.sgn ? DATA_W'(signed'(sh[15:0])) : DATA_W'(sh[15:0]);
      2'd2:    fmt_load = m.sgn ? DATA_W'(signed'(sh[31:0])) : DATA_W'(sh[31:0]);
      default: fmt_load = sh;
    endcase
  endfunction

  // Occupancy is derived from the ring distance to head, so popped slots need no clearing.
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ[i] = {1'b0, PTR_W'(i) - head} < count;
    end
  end

  assign full       = (count == CNT_W'(DEPTH));
  assign issue_fire = q.issue_valid && !full;
  assign dok        = q.data_ok && occ[rp] && !e_done[rp];
  assign head_occ   = (count != '0);
  assign head_meta  = e_meta[head];
  assign head_done  = e_done[head] || (dok && (rp == head));
  assign head_data  = e_done[head] ? e_data[head] : q.rdata;

  assign resp_valid_int = head_occ && head_done && !e_cancel[head] && !q.flush;
  // Cancelled heads retire only once their data is stored, never via the bypass.
  assign drop = head_occ && e_done[head] && e_cancel[head];
  assign pop  = (resp_valid_int && q.resp_ready) || drop;

  assign q.issue_ready  = !full;
  assign q.resp_valid   = resp_valid_int;
  assign q.resp_data    = (resp_valid_int && head_meta.is_load) ? fmt_load(head_data, head_meta) : '0;
  assign q.resp_tag     = head_occ ? head_meta.tag : '0;
  assign q.resp_is_load = head_occ && head_meta.is_load;
  assign q.inflight     = count;
  assign q.cancel_busy  = |(occ & e_cancel);

  always_ff @(posedge clk) begin
    if (reset) begin
      head     <= '0;
      tail     <= '0;
      rp       <= '0;
      count    <= '0;
      e_done   <= '0;
      e_cancel <= '0;
    end else begin
      if (q.flush) e_cancel <= e_cancel | occ;
      if (dok) begin
        e_done[rp] <= 1'b1;
        rp         <= rp + PTR_W'(1);
      end
      if (issue_fire) begin
        e_done[tail]   <= 1'b0;
        e_cancel[tail] <= q.flush;
        tail           <= tail + PTR_W'(1);
      end
      if (pop) head <= head + PTR_W'(1);
      count <= count + CNT_W'(issue_fire) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (issue_fire) begin
      e_meta[tail] <= '{is_load: q.issue_is_load, size: q.issue_size, sgn: q.issue_signed,
                        offset: q.issue_offset, tag: q.issue_tag};
    end
    if (dok) e_data[rp] <= q.rdata;
  end
endmodule
